seq_booth_mult: RTL and testbench

//  Parametrised sequential radix-2 Booth multiplier; successor to the fixed 4x4 combinational array multiplier.

---
 rtl/seq_booth_mult.sv | 215 +++++++++++++++++++++
 tb/tb_seq_booth_mult.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_booth_mult.sv
// -----------------------------------------------------------------------------
// seq_booth_mult
//   Sequential radix-2 Booth multiplier. Multiplies two WIDTH-bit operands,
//   which are either both signed or both unsigned, chosen per transaction.
//   The block retires one Booth step per clock and produces a 2*WIDTH-bit
//   product.
//
//   Operands are widened by one bit before the multiply: sign-extended in
//   signed mode, zero-extended in unsigned mode. This lets a single signed
//   Booth datapath serve both modes.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     operands and mode are valid
//   in_ready     block can accept operands (high only in IDLE)
//   a            multiplicand, WIDTH bits
//   b            multiplier, WIDTH bits
//   signed_mode  1: a and b are two's complement; 0: unsigned
//   out_valid    product valid; held until taken
//   out_ready    consumer accepts the product
//   p            product, 2*WIDTH bits; keeps its last value after hand-off
//   dbg_state    current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake semantics (both sides)
//   A transfer happens on a rising edge where valid && ready are both high.
//   A source that raises valid keeps it, and its data, stable until that
//   edge. Ready never depends combinationally on valid. Input operands are
//   captured only in IDLE, so in_valid while busy is ignored, not queued.
//   out_ready while out_valid is low has no effect.
//
// Timing
//   out_valid rises WIDTH+1 cycles after the accepting edge. The delay is
//   fixed and does not depend on the data. With out_ready tied high, the
//   block accepts one new operand pair every WIDTH+3 cycles.
// -----------------------------------------------------------------------------
module seq_booth_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic [1:0]         dbg_state
);

  // Widened operand size.
  localparam int W1    = WIDTH + 1;
  // Iteration counter width. It is derived from WIDTH and is not meant to be
  // overridden.
  localparam int CNT_W = $clog2(WIDTH + 2);
  // The counter value seen during the final (W1-th) Booth step.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Booth datapath registers.
  // The accumulator is one bit wider than the widened operands. With that
  // extra bit, A +/- M cannot overflow, even for
  // most-negative x most-negative.
  logic [W1-1:0]    m_q;      // multiplicand, widened
  logic [W1-1:0]    q_q;      // multiplier, shifted out LSB-first
  logic [W1:0]      acc_q;    // partial-product accumulator (A)
  logic             q_1_q;    // Booth look-behind bit
  logic [CNT_W-1:0] cnt_q;    // completed Booth steps
  logic [2*WIDTH-1:0] p_q;

  // Values produced by one Booth step.
  logic [W1:0]        m_sext;
  logic [W1:0]        sum;
  logic [W1:0]        acc_next;
  logic [W1-1:0]      q_next;
  logic               q_1_next;
  logic [2*WIDTH-1:0] prod_next;

  logic [W1-1:0] a_ext;
  logic [W1-1:0] b_ext;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // No new operands are accepted on the hand-off edge. IDLE is
        // reached first, and only then can in_ready rise.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from the state alone
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    dbg_state = state_q;
  end

  // ---------------------------------------------------------------------------
  // Operand widening.
  // Signed mode copies the sign bit into the new top bit. Unsigned mode
  // fills it with 0. Either way the widened values are non-overflowing
  // W1-bit two's-complement numbers.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_ext = signed_mode ? {a[WIDTH-1], a} : {1'b0, a};
    b_ext = signed_mode ? {b[WIDTH-1], b} : {1'b0, b};
  end

  // ---------------------------------------------------------------------------
  // One radix-2 Booth step.
  // The pair {Q[0], q_1} selects the action:
  //   01 -> add M
  //   10 -> subtract M
  //   00 or 11 -> no change
  // {A, Q, q_1} is then shifted right arithmetically by one bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    m_sext = {m_q[W1-1], m_q};
    case ({q_q[0], q_1_q})
      2'b01:   sum = acc_q + m_sext;
      2'b10:   sum = acc_q - m_sext;
      default: sum = acc_q;
    endcase
    acc_next = {sum[W1], sum[W1:1]};
    q_next   = {sum[0], q_q[W1-1:1]};
    q_1_next = q_q[0];
    // The low 2*WIDTH bits of the shifted {A, Q}. After the final step this
    // is the full product.
    prod_next = {acc_next[WIDTH-2:0], q_next};
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q   <= '0;
      q_q   <= '0;
      acc_q <= '0;
      q_1_q <= 1'b0;
      cnt_q <= '0;
      p_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // The mode is used only here. The widened operands carry the
            // mode forward, so input changes after this edge are ignored.
            m_q   <= a_ext;
            q_q   <= b_ext;
            acc_q <= '0;
            q_1_q <= 1'b0;
            cnt_q <= '0;
          end
        end
        CALC: begin
          acc_q <= acc_next;
          q_q   <= q_next;
          q_1_q <= q_1_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            p_q <= prod_next;
          end
        end
        default: begin
          // In DONE, p holds stable through any amount of backpressure.
        end
      endcase
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_booth_mult
//   Self-checking bench for seq_booth_mult. It uses two instances:
//     dut8 (WIDTH=8): directed cases, backpressure, reset abort,
//                     inputs that change during CALC, and random traffic.
//     dut4 (WIDTH=4): every operand pair in both modes, back to back.
//   Expected products come from an integer reference model. They are pushed
//   on accept and popped when the product is taken.
// -----------------------------------------------------------------------------
module tb_seq_booth_mult;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic [1:0]  st8;

  logic        in_valid4, in_ready4, sm4, out_valid4, out_ready4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic [1:0]  st4;

  seq_booth_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .p(p8), .dbg_state(st8)
  );

  seq_booth_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .signed_mode(sm4), .out_valid(out_valid4),
    .out_ready(out_ready4), .p(p4), .dbg_state(st4)
  );

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q8[$];
  logic [31:0] exp_q4[$];
  longint acc_time8 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference product, truncated to 2*w bits.
  function automatic logic [31:0] ref_mul(input int av, input int bv, input int w, input bit smode);
    longint x, y, prod;
    x = av;
    y = bv;
    if (smode && av[w-1]) x = av - (1 << w);
    if (smode && bv[w-1]) y = bv - (1 << w);
    prod = x * y;
    return 32'(prod & ((64'd1 << (2 * w)) - 1));
  endfunction

  // Products are compared on the negedge before the hand-off edge.
  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      if (exp_q8.size() == 0) check("sb8_unexpected", 32'(exp_q8.size()), 32'd1);
      else check("sb8_product", {16'd0, p8}, exp_q8.pop_front());
    end
    if (!rst && out_valid4 && out_ready4) begin
      if (exp_q4.size() == 0) check("sb4_unexpected", 32'(exp_q4.size()), 32'd1);
      else check("sb4_product", {24'd0, p4}, exp_q4.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks for the WIDTH=8 instance
  // ---------------------------------------------------------------------------
  // Returns #1 after the accepting edge, with in_valid8 dropped.
  task automatic send8(input logic [7:0] aa, input logic [7:0] bb, input logic mm);
    int n;
    a8 = aa;
    b8 = bb;
    sm8 = mm;
    in_valid8 = 1'b1;
    n = 0;
    while (!in_ready8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready8) check("send8_ready_timeout", {31'd0, in_ready8}, 32'd1);
    @(posedge clk);
    acc_time8 = $time;
    exp_q8.push_back(ref_mul(int'(aa), int'(bb), 8, mm));
    #1;
    in_valid8 = 1'b0;
  endtask

  // Counts edges from the accept until out_valid8 is seen high.
  task automatic wait_valid8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid8) check("wait8_valid_timeout", {31'd0, out_valid8}, 32'd1);
  endtask

  // Single transaction with latency, product and return-to-IDLE checks.
  task automatic run8(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                      input logic mm, input logic [15:0] expp);
    int lat;
    send8(aa, bb, mm);
    wait_valid8(lat);
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_p"}, {16'd0, p8}, {16'd0, expp});
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, st8}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int bad;
    int n;
    longint prev_t;
    logic [15:0] p_hold;

    in_valid8 = 0; a8 = 0; b8 = 0; sm8 = 0; out_ready8 = 1;
    in_valid4 = 0; a4 = 0; b4 = 0; sm4 = 0; out_ready4 = 1;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, in_ready8},  32'd1);
    check("rst_out_valid", {31'd0, out_valid8}, 32'd0);
    check("rst_p",         {16'd0, p8},         32'd0);
    check("rst_state",     {30'd0, st8},        32'd0);
    check("rst_p4",        {24'd0, p4},         32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed products
    run8("uns_ff_ff",   8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run8("sgn_80_80",   8'h80, 8'h80, 1'b1, 16'h4000);
    run8("sgn_ff_01",   8'hFF, 8'h01, 1'b1, 16'hFFFF);
    run8("uns_ff_01",   8'hFF, 8'h01, 1'b0, 16'h00FF);
    run8("sgn_7f_80",   8'h7F, 8'h80, 1'b1, 16'hC080);

    // Backpressure: hold for 20 cycles, then release
    out_ready8 = 1'b0;
    send8(8'hC3, 8'h5A, 1'b1);
    wait_valid8(lat);
    check("bp_latency", 32'(lat), 32'd9);
    p_hold = 16'(ref_mul(32'hC3, 32'h5A, 8, 1'b1));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid8 !== 1'b1 || p8 !== p_hold || in_ready8 !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("bp_stable_cycles_bad", 32'(bad), 32'd0);
    check("bp_p", {16'd0, p8}, {16'd0, p_hold});
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle",  {30'd0, st8},        32'd0);
    check("bp_release_ready", {31'd0, in_ready8},  32'd1);
    check("bp_release_valid", {31'd0, out_valid8}, 32'd0);
    check("bp_p_retained",    {16'd0, p8},         {16'd0, p_hold});

    // Reset 3 cycles into CALC
    send8(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q8.delete();
    check("abort_ready", {31'd0, in_ready8}, 32'd1);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid8 !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("abort_no_valid", 32'(bad), 32'd0);
    run8("after_abort_3x5", 8'd3, 8'd5, 1'b0, 16'd15);

    // Zero operand while the inputs change during CALC
    for (int k = 0; k < 2; k++) begin
      send8(k == 0 ? 8'h00 : 8'hA7, k == 0 ? 8'h5A : 8'h00, 1'b1);
      lat = 0;
      while (!out_valid8 && lat < 200) begin
        in_valid8 = 1'($urandom_range(0, 1));
        a8 = 8'($urandom_range(1, 255));
        b8 = 8'($urandom_range(1, 255));
        sm8 = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        lat++;
      end
      in_valid8 = 1'b0;
      check("zero_latency", 32'(lat), 32'd9);
      check("zero_p", {16'd0, p8}, 32'd0);
      @(posedge clk); #1;
      check("zero_idle", {30'd0, st8}, 32'd0);
    end

    // Random back-to-back traffic, including the accept interval
    prev_t = 0;
    for (int i = 0; i < 24; i++) begin
      send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      if (i > 0) check("thru8_interval", 32'((acc_time8 - prev_t) / 10), 32'd11);
      prev_t = acc_time8;
    end
    n = 0;
    while (exp_q8.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("sb8_drained", 32'(exp_q8.size()), 32'd0);

    // WIDTH=4: every pair in both modes, in_valid held high
    bad = 0;
    prev_t = 0;
    in_valid4 = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          a4 = 4'(i);
          b4 = 4'(j);
          sm4 = 1'(m);
          n = 0;
          while (!in_ready4 && n < 100) begin
            @(posedge clk); #1;
            n++;
          end
          if (!in_ready4) check("send4_ready_timeout", {31'd0, in_ready4}, 32'd1);
          @(posedge clk);
          exp_q4.push_back(ref_mul(i, j, 4, 1'(m)));
          if (prev_t != 0 && ($time - prev_t) != 70) bad++;
          prev_t = $time;
          #1;
        end
      end
    end
    in_valid4 = 1'b0;
    check("thru4_bad_intervals", 32'(bad), 32'd0);
    n = 0;
    while (exp_q4.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("sb4_drained", 32'(exp_q4.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
